mul_booth32: RTL and testbench

MUL_BOOTH32 -- requirements
Module: mul_booth32

---
 rtl/mul_pkg.sv | 16 +
 rtl/cla32_ov.sv | 45 ++++
 rtl/mul_booth32.sv | 103 ++++++++++
 tb/tb_mul_booth32.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// mul_pkg: shared constants, state encodings and Booth-step decode for mul_booth32.
//   WIDTH  - operand width (only 32 supported)
//   STEPS  - Booth steps per multiplication
//   S_*    - FSM state encodings
package mul_pkg;
    localparam int WIDTH = 32;
    localparam int STEPS = 32;
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_EXEC = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;
    typedef enum logic [1:0] {BOOTH_NOP, BOOTH_ADD, BOOTH_SUB} booth_op_e;
    // {x0, x_prev}: 01 -> add, 10 -> subtract, 00/11 -> pass through
    function automatic booth_op_e booth_sel(input logic x0, input logic x_prev);
        return (x0 == x_prev) ? BOOTH_NOP : (x_prev ? BOOTH_ADD : BOOTH_SUB);
    endfunction
endpackage

// File: rtl/cla32_ov.sv
// cla32_ov: 32-bit carry-lookahead adder exposing carry-out and carry-into-msb.
//   a, b    - addends
//   ci      - carry in
//   s       - sum
//   co      - carry out of bit 31
//   co_prev - carry into bit 31 (co ^ co_prev flags signed overflow)
module cla32_ov (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] s,
    output logic        co,
    output logic        co_prev
);
    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;
    logic        gr;
    logic        pr;
    logic        cg;
    assign g = a & b;
    assign p = a ^ b;
    // 4-bit lookahead groups: every carry inside a group is formed from the
    // group's prefix generate/propagate and the group carry-in only.
    always_comb begin
        c  = '0;
        gr = 1'b0;
        pr = 1'b1;
        cg = ci;
        c[0] = ci;
        for (int k = 0; k < 8; k++) begin
            gr = 1'b0;
            pr = 1'b1;
            for (int j = 0; j < 4; j++) begin
                gr = g[4*k+j] | (p[4*k+j] & gr);
                pr = p[4*k+j] & pr;
                c[4*k+j+1] = gr | (pr & cg);
            end
            cg = c[4*k+4];
        end
    end
    assign s       = p ^ c[31:0];
    assign co      = c[32];
    assign co_prev = c[31];
endmodule

// File: rtl/mul_booth32.sv
// mul_booth32: sequential radix-2 Booth signed multiplier, one step per clock.
//   clk, reset    - clock and synchronous active-high reset
//   multiplicand  - signed operand M, sampled when a start is accepted
//   multiplier    - signed operand Q, sampled when a start is accepted
//   op_start      - begin a multiplication (honoured only in IDLE)
//   op_clear      - abort/acknowledge, returns to IDLE
//   op_done       - registered, high while the product is held
//   result        - signed 64-bit product {U,V}
module mul_booth32 #(
    parameter int WIDTH = mul_pkg::WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 op_start,
    input  logic                 op_clear,
    output logic                 op_done,
    output logic [2*WIDTH-1:0]   result
);
    import mul_pkg::*;
    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic             xp_q, xp_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             done_q, done_d;
    booth_op_e        op;
    logic [WIDTH-1:0] add_b;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             co_prev;
    logic             sign;
    assign op    = booth_sel(x_q[0], xp_q);
    assign add_b = (op == BOOTH_ADD) ? m_q : (op == BOOTH_SUB) ? ~m_q : '0;
    cla32_ov u_add (
        .a       (u_q),
        .b       (add_b),
        .ci      (op == BOOTH_SUB),
        .s       (sum),
        .co      (co),
        .co_prev (co_prev)
    );
    // True sign of the 33-bit add/sub result, so overflow (e.g. M = -2^31) shifts in correctly
    assign sign = sum[WIDTH-1] ^ (co_prev ^ co);
    always_comb begin
        state_d = state_q;
        u_d     = u_q;
        v_d     = v_q;
        x_d     = x_q;
        m_d     = m_q;
        xp_d    = xp_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        if (op_clear) begin
            state_d = S_IDLE;
            u_d     = '0;
            v_d     = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (state_q == S_IDLE && op_start) begin
            state_d = S_EXEC;
            u_d     = '0;
            v_d     = '0;
            x_d     = multiplier;
            m_d     = multiplicand;
            xp_d    = 1'b0;
            cnt_d   = '0;
        end else if (state_q == S_EXEC) begin
            {u_d, v_d} = {sign, sum, v_q[WIDTH-1:1]};
            xp_d       = x_q[0];
            x_d        = x_q >> 1;
            cnt_d      = cnt_q + 5'd1;
            state_d    = (cnt_q == 5'(STEPS - 1)) ? S_DONE : S_EXEC;
            done_d     = (cnt_q == 5'(STEPS - 1));
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            u_q     <= '0;
            v_q     <= '0;
            x_q     <= '0;
            m_q     <= '0;
            xp_q    <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            u_q     <= u_d;
            v_q     <= v_d;
            x_q     <= x_d;
            m_q     <= m_d;
            xp_q    <= xp_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end
    assign op_done = done_q;
    assign result  = {u_q, v_q};
endmodule

// File: tb/tb_mul_booth32.sv
// tb_mul_booth32: scoreboard bench for mul_booth32 (directed vectors plus random signed pairs).
module tb_mul_booth32;
    import mul_pkg::*;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        op_start = 1'b0;
    logic        op_clear = 1'b0;
    logic        op_done;
    logic [63:0] result;
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        done_prev = 1'b0;
    typedef struct {
        logic [63:0] p;
        int unsigned acc;
        string       name;
    } exp_t;
    exp_t sb[$];

    mul_booth32 dut (
        .clk          (clk),
        .reset        (reset),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .op_start     (op_start),
        .op_clear     (op_clear),
        .op_done      (op_done),
        .result       (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (op_done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk({e.name, "_result"}, result, e.p);
                chk({e.name, "_latency"}, 64'(cyc - e.acc), 64'(STEPS));
            end
        end
        done_prev = op_done;
    end

    task automatic start(input logic [31:0] m, input logic [31:0] q);
        @(posedge clk);
        #1;
        multiplicand = m;
        multiplier   = q;
        op_start     = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!op_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!op_done) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic clear(input string name);
        @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        @(negedge clk);
        chk({name, "_clr_done"}, 64'(op_done), 64'd0);
        chk({name, "_clr_result"}, result, 64'd0);
    endtask

    task automatic run_op(input string name, input logic [31:0] m, input logic [31:0] q,
                          input logic [63:0] exp);
        start(m, q);
        sb.push_back('{exp, cyc, name});
        wait_done(name);
        clear(name);
    endtask

    task automatic quiet_window(input string name);
        logic seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (op_done) seen = 1'b1;
        end
        chk({name, "_no_done"}, 64'(seen), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint a;
        longint b;
        logic [31:0] m;
        logic [31:0] q;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_done", 64'(op_done), 64'd0);
        chk("reset_result", result, 64'd0);

        run_op("3x5", 32'd3, 32'd5, 64'h0000_0000_0000_000F);
        run_op("m7x6", 32'hFFFF_FFF9, 32'd6, 64'hFFFF_FFFF_FFFF_FFD6);
        run_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
        run_op("max_x_min", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000);
        run_op("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);
        run_op("m1_x_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001);
        run_op("one_x_min", 32'd1, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000);
        run_op("zero", 32'd0, 32'hDEAD_BEEF, 64'd0);

        start(32'd5, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        op_clear = 1'b1;
        @(posedge clk);
        #1;
        op_clear = 1'b0;
        @(negedge clk);
        chk("abort_done", 64'(op_done), 64'd0);
        chk("abort_result", result, 64'd0);
        run_op("2x2", 32'd2, 32'd2, 64'd4);

        start(32'h0001_0000, 32'hFFFF_FFFD);
        sb.push_back('{64'hFFFF_FFFF_FFFD_0000, cyc, "ignore_start"});
        repeat (5) @(posedge clk);
        #1;
        op_start     = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        repeat (3) @(posedge clk);
        #1;
        op_start = 1'b0;
        wait_done("ignore_start");
        @(posedge clk);
        #1;
        op_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        op_start = 1'b0;
        @(negedge clk);
        chk("done_hold_flag", 64'(op_done), 64'd1);
        chk("done_hold_result", result, 64'hFFFF_FFFF_FFFD_0000);
        clear("ignore_start");

        @(posedge clk);
        #1;
        multiplicand = 32'd3;
        multiplier   = 32'd3;
        op_start     = 1'b1;
        op_clear     = 1'b1;
        @(posedge clk);
        #1;
        op_start = 1'b0;
        op_clear = 1'b0;
        quiet_window("start_clr");
        chk("start_clr_result", result, 64'd0);

        start(32'h0000_1234, 32'h0000_5678);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midreset_done", 64'(op_done), 64'd0);
        chk("midreset_result", result, 64'd0);
        quiet_window("midreset");
        run_op("post_reset", 32'hFFFF_FFFE, 32'd21, 64'hFFFF_FFFF_FFFF_FFD6);

        for (int i = 0; i < 1000; i++) begin
            m = $urandom;
            q = $urandom;
            a = longint'($signed(m));
            b = longint'($signed(q));
            run_op("rand", m, q, 64'(a * b));
        end

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
